cache_nway: RTL

- Parametrised successor to the fixed 2-way L1: write-back, write-allocate, N-way set-associative cache between the CPU Wishbone slave port and the memory Wishbone master port.
- Line size is fixed at 128 bits (8 × lc3b_word), with a 16-bit byte SEL.
- Adds over the previous generation:
  - configurable ways and sets
  - tree pseudo-LRU replacement
  - saturating hit, miss and writeback counters
  - synchronous counter clear

---
 rtl/cache_nway_pkg.sv | 23 ++
 rtl/cache_nway_plru.sv | 57 +++++
 rtl/cache_nway.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_nway_pkg.sv
// cache_nway_pkg
// Shared types for the N-way set-associative L1 cache.
//   lc3b_word     : 16-bit machine word
//   lc3b_line     : one cache line, 8 words (128 bits)
//   lc3b_line_sel : per-byte enables for one line (16 bits)
//   cache_state_t : controller FSM states
package cache_nway_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [15:0]  lc3b_line_sel;

  localparam int LINE_BYTES = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_FILL,
    S_RESPOND
  } cache_state_t;

endpackage

// File: rtl/cache_nway_plru.sv
// cache_nway_plru
// Tree pseudo-LRU bits, one WAYS-1 bit tree per set.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (all trees cleared)
//   i_idx      : set index, used for both the lookup and the update
//   i_way      : way that was just accessed
//   i_upd      : make the tree at i_idx point away from i_way
//   o_victim   : way currently selected for replacement in set i_idx
module cache_nway_plru
  import cache_nway_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 8,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [WAY_W-1:0] i_way,
  input  logic             i_upd,
  output logic [WAY_W-1:0] o_victim
);

  generate
    if (WAYS == 1) begin : g_direct
      assign o_victim = '0;
    end else begin : g_tree
      // Each bit names the subtree to evict from next; 0 = lower-numbered half.
      logic [SETS-1:0][WAYS-2:0] r_bits;
      logic [WAYS-2:0]           w_cur;
      logic [WAYS-2:0]           w_next;

      assign w_cur = r_bits[i_idx];

      if (WAYS == 2) begin : g_two
        assign o_victim = w_cur[0];
        assign w_next   = ~i_way;
      end else begin : g_four
        // bit0 = root, bit1 = ways 0/1, bit2 = ways 2/3
        assign o_victim = w_cur[0] ? {1'b1, w_cur[2]} : {1'b0, w_cur[1]};
        always_comb begin
          w_next    = w_cur;
          w_next[0] = ~i_way[1];
          if (i_way[1]) w_next[2] = ~i_way[0];
          else          w_next[1] = ~i_way[0];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_bits        <= '0;
        else if (i_upd) r_bits[i_idx] <= w_next;
      end
    end
  endgenerate

endmodule

// File: rtl/cache_nway.sv
// cache_nway
// Write-back, write-allocate, N-way set-associative cache with 128-bit lines.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   cpu_*             : Wishbone slave toward the CPU (line-addressed)
//   mem_*             : Wishbone master toward memory (whole-line transfers)
//   cnt_clr           : synchronous clear of the performance counters
//   hit/miss/wb_cnt   : saturating hit, miss (fill) and writeback counters
module cache_nway
  import cache_nway_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int SETS  = 8,
  parameter int ADR_W = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_cyc,
  input  logic             cpu_stb,
  input  logic             cpu_we,
  input  logic [15:0]      cpu_sel,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic [127:0]     cpu_dat_m,
  output logic [127:0]     cpu_dat_s,
  output logic             cpu_ack,
  output logic             cpu_rty,
  output logic             mem_cyc,
  output logic             mem_stb,
  output logic             mem_we,
  output logic [15:0]      mem_sel,
  output logic [ADR_W-1:0] mem_adr,
  output logic [127:0]     mem_dat_m,
  input  logic [127:0]     mem_dat_s,
  input  logic             mem_ack,
  input  logic             mem_rty,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADR_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  cache_state_t              r_state;
  logic [ADR_W-1:0]          r_adr;
  logic                      r_we;
  lc3b_line_sel              r_sel;
  lc3b_line                  r_wdat;
  lc3b_line                  r_rdat;
  logic                      r_ack;
  logic                      r_abandon;
  logic                      r_mem_cyc;
  logic                      r_mem_stb;
  logic                      r_mem_we;
  logic [ADR_W-1:0]          r_mem_adr;
  lc3b_line                  r_mem_dat;
  logic [WAY_W-1:0]          r_victim;
  logic [WAYS-1:0][SETS-1:0] r_valid;
  logic [WAYS-1:0][SETS-1:0] r_dirty;
  logic [CNT_W-1:0]          r_hit_cnt;
  logic [CNT_W-1:0]          r_miss_cnt;
  logic [CNT_W-1:0]          r_wb_cnt;

  lc3b_line                  r_data [WAYS][SETS];
  logic [TAG_W-1:0]          r_tags [WAYS][SETS];

  logic [IDX_W-1:0]          w_idx;
  logic [TAG_W-1:0]          w_tag;
  logic [WAYS-1:0]           w_way_hit;
  logic                      w_hit;
  logic [WAY_W-1:0]          w_hit_way;
  lc3b_line                  w_hit_line;
  lc3b_line                  w_merged;
  logic [WAY_W-1:0]          w_plru_victim;
  logic [WAY_W-1:0]          w_victim;
  logic                      w_victim_dirty;
  logic                      w_lookup;
  logic                      w_mem_done;
  logic                      w_fill_done;
  logic                      w_wb_done;

  assign w_idx = r_adr[IDX_W-1:0];
  assign w_tag = r_adr[ADR_W-1:IDX_W];

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign w_way_hit[gi] = r_valid[gi][w_idx] && (r_tags[gi][w_idx] == w_tag);
    end
    for (gi = 0; gi < LINE_BYTES; gi++) begin : g_merge
      assign w_merged[8*gi +: 8] = r_sel[gi] ? r_wdat[8*gi +: 8] : w_hit_line[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_way_hit[w]) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins; PLRU only decides among a full set.
  always_comb begin
    w_victim = w_plru_victim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w][w_idx]) w_victim = WAY_W'(w);
    end
  end

  assign w_hit_line     = r_data[w_hit_way][w_idx];
  assign w_victim_dirty = r_valid[w_victim][w_idx] & r_dirty[w_victim][w_idx];
  // RESPOND reuses the lookup path after a fill; it always hits.
  assign w_lookup       = (r_state == S_COMPARE) || (r_state == S_RESPOND);
  // A retry on the same cycle is not a completion.
  assign w_mem_done     = r_mem_cyc & mem_ack & ~mem_rty;
  assign w_fill_done    = (r_state == S_FILL) & w_mem_done;
  assign w_wb_done      = (r_state == S_WRITEBACK) & w_mem_done;

  cache_nway_plru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_plru (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_idx    (w_idx),
    .i_way    (w_hit_way),
    .i_upd    (w_lookup & w_hit),
    .o_victim (w_plru_victim)
  );

  // Line and tag storage carries no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_data[r_victim][w_idx] <= mem_dat_s;
      r_tags[r_victim][w_idx] <= w_tag;
    end else if (w_lookup && w_hit && r_we) begin
      r_data[w_hit_way][w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_adr     <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_wdat    <= '0;
      r_rdat    <= '0;
      r_ack     <= 1'b0;
      r_abandon <= 1'b0;
      r_mem_cyc <= 1'b0;
      r_mem_stb <= 1'b0;
      r_mem_we  <= 1'b0;
      r_mem_adr <= '0;
      r_mem_dat <= '0;
      r_victim  <= '0;
      r_valid   <= '0;
      r_dirty   <= '0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_abandon <= 1'b0;
          // ~r_ack: the CPU still holds STB during the acknowledge cycle.
          if (cpu_cyc && cpu_stb && !r_ack) begin
            r_adr   <= cpu_adr;
            r_we    <= cpu_we;
            r_sel   <= cpu_sel;
            r_wdat  <= cpu_dat_m;
            r_state <= S_COMPARE;
          end
        end
        S_COMPARE, S_RESPOND: begin
          if (w_hit) begin
            r_ack   <= 1'b1;
            r_rdat  <= r_we ? w_merged : w_hit_line;
            if (r_we) r_dirty[w_hit_way][w_idx] <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_victim  <= w_victim;
            r_mem_cyc <= 1'b1;
            r_mem_stb <= 1'b1;
            if (w_victim_dirty) begin
              r_mem_we  <= 1'b1;
              r_mem_adr <= {r_tags[w_victim][w_idx], w_idx};
              r_mem_dat <= r_data[w_victim][w_idx];
              r_state   <= S_WRITEBACK;
            end else begin
              r_mem_we  <= 1'b0;
              r_mem_adr <= r_adr;
              r_state   <= S_FILL;
            end
          end
        end
        S_WRITEBACK: begin
          if (!cpu_cyc) r_abandon <= 1'b1;
          if (w_mem_done) begin
            // Strobes drop for one cycle; FILL then issues the read.
            r_mem_cyc <= 1'b0;
            r_mem_stb <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= S_FILL;
          end
        end
        S_FILL: begin
          if (!cpu_cyc) r_abandon <= 1'b1;
          if (!r_mem_cyc) begin
            r_mem_cyc <= 1'b1;
            r_mem_stb <= 1'b1;
            r_mem_we  <= 1'b0;
            r_mem_adr <= r_adr;
          end else if (w_mem_done) begin
            r_mem_cyc                <= 1'b0;
            r_mem_stb                <= 1'b0;
            r_valid[r_victim][w_idx] <= 1'b1;
            r_dirty[r_victim][w_idx] <= 1'b0;
            r_state <= (r_abandon || !cpu_cyc) ? S_IDLE : S_RESPOND;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else if (cnt_clr) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if ((r_state == S_COMPARE) && w_hit) r_hit_cnt  <= sat_inc(r_hit_cnt);
      if (w_fill_done)                     r_miss_cnt <= sat_inc(r_miss_cnt);
      if (w_wb_done)                       r_wb_cnt   <= sat_inc(r_wb_cnt);
    end
  end

  assign cpu_dat_s = r_rdat;
  assign cpu_ack   = r_ack;
  assign cpu_rty   = cpu_cyc & cpu_stb & ~r_ack;
  assign mem_cyc   = r_mem_cyc;
  assign mem_stb   = r_mem_stb;
  assign mem_we    = r_mem_we;
  assign mem_sel   = '1;
  assign mem_adr   = r_mem_adr;
  assign mem_dat_m = r_mem_dat;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;
  assign wb_cnt    = r_wb_cnt;

endmodule
